// File: rtl/sdram_ref_ctrl.sv
// sdram_ref_ctrl
// Refresh command sequencer sitting between the refresh timer and the SDRAM
// command pins. On a timer request (once init is done) it waits for the main
// controller to go idle. It then issues PALL followed by REF_CNT AREF
// commands with tRP/tRFC spacing, and finally pulses ref_ack for one cycle.
//
// Ports:
//   clk0       system clock, rising edge
//   reset      asynchronous active-low reset
//   init_done  SDRAM power-up complete; gates acceptance of new requests
//   ref_req    refresh request level from the refresh timer
//   bank_busy  main controller has an access in flight
//   ref_ack    one-cycle refresh-done pulse back to the timer
//   ref_busy   refresh owns the command bus
//   cs_n, ras_n, cas_n, we_n, a10   SDRAM command bits (all registered)
module sdram_ref_ctrl #(
    parameter int T_RP    = 3,
    parameter int T_RFC   = 7,
    parameter int REF_CNT = 2
) (
    input  logic clk0,
    input  logic reset,
    input  logic init_done,
    input  logic ref_req,
    input  logic bank_busy,
    output logic ref_ack,
    output logic ref_busy,
    output logic cs_n,
    output logic ras_n,
    output logic cas_n,
    output logic we_n,
    output logic a10
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRFC,
        S_ACK,
        S_DONE
    } state_t;

    localparam logic [7:0] TRP_LOAD  = 8'(T_RP - 1);
    localparam logic [7:0] TRFC_LOAD = 8'(T_RFC - 1);
    localparam logic [3:0] REP_LAST  = 4'(REF_CNT);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [3:0] rep_cnt, rep_cnt_nxt;
    logic [3:0] cmd_nxt;
    logic       a10_nxt;
    logic       ack_nxt;
    logic       busy_nxt;

    // Wait counter holds the number of NOP cycles still owed before the next
    // command; a value of 1 means this is the last NOP of the gap.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        rep_cnt_nxt  = rep_cnt;
        case (state)
            S_IDLE: begin
                if (ref_req && init_done) state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!bank_busy) state_nxt = S_PRE;
            end
            S_PRE: begin
                wait_cnt_nxt = TRP_LOAD;
                rep_cnt_nxt  = 4'd0;
                state_nxt    = (T_RP == 1) ? S_AREF : S_TRP;
            end
            S_TRP: begin
                wait_cnt_nxt = wait_cnt - 8'd1;
                if (wait_cnt <= 8'd1) state_nxt = S_AREF;
            end
            S_AREF: begin
                rep_cnt_nxt  = rep_cnt + 4'd1;
                wait_cnt_nxt = TRFC_LOAD;
                if (T_RFC == 1)
                    state_nxt = ((rep_cnt + 4'd1) == REP_LAST) ? S_ACK : S_AREF;
                else
                    state_nxt = S_TRFC;
            end
            S_TRFC: begin
                wait_cnt_nxt = wait_cnt - 8'd1;
                if (wait_cnt <= 8'd1)
                    state_nxt = (rep_cnt == REP_LAST) ? S_ACK : S_AREF;
            end
            S_ACK:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the pins
    // line up exactly with the state that owns them.
    always_comb begin
        cmd_nxt  = CMD_NOP;
        a10_nxt  = 1'b0;
        ack_nxt  = 1'b0;
        busy_nxt = 1'b0;
        case (state_nxt)
            S_WAIT_IDLE, S_TRP, S_TRFC: busy_nxt = 1'b1;
            S_PRE: begin
                busy_nxt = 1'b1;
                cmd_nxt  = CMD_PALL;
                a10_nxt  = 1'b1;
            end
            S_AREF: begin
                busy_nxt = 1'b1;
                cmd_nxt  = CMD_AREF;
            end
            S_ACK: begin
                busy_nxt = 1'b1;
                ack_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            rep_cnt  <= 4'd0;
            ref_ack  <= 1'b0;
            ref_busy <= 1'b0;
            cs_n     <= 1'b1;
            ras_n    <= 1'b1;
            cas_n    <= 1'b1;
            we_n     <= 1'b1;
            a10      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rep_cnt  <= rep_cnt_nxt;
            ref_ack  <= ack_nxt;
            ref_busy <= busy_nxt;
            {cs_n, ras_n, cas_n, we_n} <= cmd_nxt;
            a10      <= a10_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_ref_ctrl.sv
// Bench for sdram_ref_ctrl: two instances (default timing and T_RP=T_RFC=REF_CNT=1)
// share the stimulus. A schedule-based model predicts every output per cycle,
// and directed scenarios pin event cycles with literal values.
module tb_sdram_ref_ctrl;

    logic clk0 = 1'b0;
    logic reset, init_done, ref_req, bank_busy;
    logic a_ack, a_busy, a_cs, a_ras, a_cas, a_we, a_a10;
    logic b_ack, b_busy, b_cs, b_ras, b_cas, b_we, b_a10;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk0 = ~clk0;

    sdram_ref_ctrl dut_a (
        .clk0(clk0), .reset(reset), .init_done(init_done), .ref_req(ref_req),
        .bank_busy(bank_busy), .ref_ack(a_ack), .ref_busy(a_busy),
        .cs_n(a_cs), .ras_n(a_ras), .cas_n(a_cas), .we_n(a_we), .a10(a_a10)
    );

    sdram_ref_ctrl #(.T_RP(1), .T_RFC(1), .REF_CNT(1)) dut_b (
        .clk0(clk0), .reset(reset), .init_done(init_done), .ref_req(ref_req),
        .bank_busy(bank_busy), .ref_ack(b_ack), .ref_busy(b_busy),
        .cs_n(b_cs), .ras_n(b_ras), .cas_n(b_cas), .we_n(b_we), .a10(b_a10)
    );

    // Model: mode -1 = in/just out of reset (pins deselected), 0 = idle,
    // 1 = waiting for bank idle, 2 = running since edge t0, 3 = cooldown.
    function automatic void model_step(inout int mode, inout int t0, input int e,
                                       input logic req, input logic init, input logic bb,
                                       input int trp, input int trfc, input int rc);
        case (mode)
            -1, 0: mode = (req && init) ? 1 : 0;
            1: if (!bb) begin mode = 2; t0 = e; end
            2: if (e - t0 > trp + rc * trfc) mode = 3;
            default: mode = 0;
        endcase
    endfunction

    // Returns {ack, busy, cs_n, ras_n, cas_n, we_n, a10}.
    function automatic logic [6:0] model_out(input int mode, input int t0, input int e,
                                             input int trp, input int trfc, input int rc);
        int d;
        int last;
        logic [6:0] o;
        last = trp + rc * trfc;
        d = e - t0;
        o = 7'b0001110;
        case (mode)
            -1: o = 7'b0011110;
            1:  o = 7'b0101110;
            2: begin
                o = 7'b0101110;
                if (d == 0) o = 7'b0100101;
                else if (d == last) o = 7'b1101110;
                else if (d >= trp && d < last && ((d - trp) % trfc) == 0) o = 7'b0100010;
            end
            default: o = 7'b0001110;
        endcase
        return o;
    endfunction

    int e = 0;
    int ma = -1, ta = 0, mb = -1, tb = 0;

    always @(posedge clk0) begin
        logic [6:0] ea, eb, ga, gb;
        e++;
        if (!reset) begin
            ma = -1;
            mb = -1;
        end else begin
            model_step(ma, ta, e, ref_req, init_done, bank_busy, 3, 7, 2);
            model_step(mb, tb, e, ref_req, init_done, bank_busy, 1, 1, 1);
        end
        ea = model_out(ma, ta, e, 3, 7, 2);
        eb = model_out(mb, tb, e, 1, 1, 1);
        #1;
        ga = {a_ack, a_busy, a_cs, a_ras, a_cas, a_we, a_a10};
        gb = {b_ack, b_busy, b_cs, b_ras, b_cas, b_we, b_a10};
        vectors += 2;
        if (ga !== ea) begin
            miscompares++;
            $display("FAIL model_a t=%0t got %b expected %b", $time, ga, ea);
        end
        if (gb !== eb) begin
            miscompares++;
            $display("FAIL model_b t=%0t got %b expected %b", $time, gb, eb);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Starts a request just before edge 0 and records event cycles, where
    // cycle c is the cycle following edge c-1.
    task automatic run_seq(input int bb_last, input int drop_req_c, input int drop_init_c,
                           input int ncyc,
                           output int pall, output int ar1, output int ar2,
                           output int ack_c, output int ack_n, output int rise, output int fall,
                           output int p2, output int r2, output int k2);
        logic prev_ack;
        pall = -1; ar1 = -1; ar2 = -1; ack_c = -1; ack_n = 0; rise = -1; fall = -1;
        p2 = -1; r2 = -1; k2 = -1;
        prev_ack = 1'b0;
        init_done = 1'b1;
        ref_req = 1'b1;
        bank_busy = (bb_last >= 0);
        for (int j = 0; j < ncyc; j++) begin
            int c;
            @(posedge clk0);
            #2;
            c = j + 1;
            if ({a_cs, a_ras, a_cas, a_we} == 4'b0010 && pall < 0) pall = c;
            if ({a_cs, a_ras, a_cas, a_we} == 4'b0001) begin
                if (ar1 < 0) ar1 = c;
                else if (ar2 < 0) ar2 = c;
            end
            if (a_ack) begin
                ack_n++;
                if (ack_c < 0) ack_c = c;
            end
            if (a_busy && rise < 0) rise = c;
            if (!a_busy && rise >= 0 && fall < 0) fall = c;
            if ({b_cs, b_ras, b_cas, b_we} == 4'b0010 && p2 < 0) p2 = c;
            if ({b_cs, b_ras, b_cas, b_we} == 4'b0001 && r2 < 0) r2 = c;
            if (b_ack && k2 < 0) k2 = c;
            if (prev_ack) ref_req = 1'b0;
            prev_ack = a_ack;
            if (c == drop_req_c) ref_req = 1'b0;
            if (c == drop_init_c) init_done = 1'b0;
            bank_busy = (c <= bb_last);
        end
        init_done = 1'b1;
    endtask

    initial begin
        int pall, ar1, ar2, ack_c, ack_n, rise, fall, p2, r2, k2;
        int busy_cnt, cmd_cnt;
        reset = 1'b0;
        init_done = 1'b0;
        ref_req = 1'b0;
        bank_busy = 1'b0;
        repeat (3) @(posedge clk0);
        #2;
        check("reset_busy", int'(a_busy), 0);
        check("reset_cmd", int'({a_cs, a_ras, a_cas, a_we}), 15);
        reset = 1'b1;
        repeat (2) @(posedge clk0);
        #2;

        // Default timing, request held one cycle past ack.
        run_seq(-1, -1, -1, 30, pall, ar1, ar2, ack_c, ack_n, rise, fall, p2, r2, k2);
        check("t1_busy_rise", rise, 1);
        check("t1_pall", pall, 2);
        check("t1_aref1", ar1, 5);
        check("t1_aref2", ar2, 12);
        check("t1_ack", ack_c, 19);
        check("t1_ack_count", ack_n, 1);
        check("t1_busy_fall", fall, 20);
        check("t1b_pall", p2, 2);
        check("t1b_aref", r2, 3);
        check("t1b_ack", k2, 4);

        // New request 5 cycles later is serviced normally.
        repeat (5) @(posedge clk0);
        #2;
        run_seq(-1, -1, -1, 25, pall, ar1, ar2, ack_c, ack_n, rise, fall, p2, r2, k2);
        check("t4_pall", pall, 2);
        check("t4_ack", ack_c, 19);
        check("t4_ack_count", ack_n, 1);

        // Bank busy through cycle 9; request and init_done drop mid-sequence.
        repeat (3) @(posedge clk0);
        #2;
        run_seq(9, 3, 15, 35, pall, ar1, ar2, ack_c, ack_n, rise, fall, p2, r2, k2);
        check("t2_busy_rise", rise, 1);
        check("t2_pall", pall, 11);
        check("t2_aref1", ar1, 14);
        check("t2_aref2", ar2, 21);
        check("t2_ack", ack_c, 28);
        check("t2_busy_fall", fall, 29);

        // Requests ignored while init_done is low.
        init_done = 1'b0;
        ref_req = 1'b1;
        busy_cnt = 0;
        cmd_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk0);
            #2;
            if (a_busy || b_busy) busy_cnt++;
            if ({a_cs, a_ras, a_cas, a_we} != 4'b0111 || {b_cs, b_ras, b_cas, b_we} != 4'b0111)
                cmd_cnt++;
        end
        check("t3_busy_cycles", busy_cnt, 0);
        check("t3_cmd_cycles", cmd_cnt, 0);
        run_seq(-1, -1, -1, 25, pall, ar1, ar2, ack_c, ack_n, rise, fall, p2, r2, k2);
        check("t3_pall", pall, 2);
        check("t3_ack", ack_c, 19);

        // Reset mid-sequence, then a fresh sequence.
        repeat (3) @(posedge clk0);
        #2;
        init_done = 1'b1;
        ref_req = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk0);
            #2;
        end
        check("t5_busy_before", int'(a_busy), 1);
        reset = 1'b0;
        #1;
        check("t5_busy_reset", int'(a_busy), 0);
        check("t5_cmd_reset", int'({a_cs, a_ras, a_cas, a_we}), 15);
        check("t5_ack_reset", int'(a_ack), 0);
        repeat (3) @(posedge clk0);
        #2;
        reset = 1'b1;
        run_seq(-1, -1, -1, 25, pall, ar1, ar2, ack_c, ack_n, rise, fall, p2, r2, k2);
        check("t5_pall", pall, 2);
        check("t5_aref1", ar1, 5);
        check("t5_ack", ack_c, 19);

        repeat (2) @(posedge clk0);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_ref_ctrl.md
Name: sdram_ref_ctrl

Overview:
- Refresh command sequencer for the SDRAM controller; sits directly downstream of the refresh timer.
- Consumes the timer's ref_req level and waits for the command path to go idle.
- Issues precharge-all, then REF_CNT auto-refresh commands with tRP/tRFC spacing, then returns a one-cycle ref_ack that clears the timer request.
- Its command outputs are muxed onto the SDRAM pins by the main controller while ref_busy is high.

Parameters:
- T_RP, 3: clocks from PALL to first AREF; legal 1..255.
- T_RFC, 7: clocks from one AREF to the next AREF or to ref_ack; legal 1..255.
- REF_CNT, 2: AREF commands per request; legal 1..15.

Ports:
- clk0  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- init_done  input  1  SDRAM power-up init complete; requests ignored while 0.
- ref_req  input  1  refresh request level from refresh timer; held until ref_ack is sampled.
- bank_busy  input  1  main controller has a read/write/burst in flight.
- ref_ack  output  1  one-cycle refresh-done pulse to refresh timer.
- ref_busy  output  1  refresh owns the command bus; main controller must not start new commands.
- cs_n  output  1  SDRAM chip select command bit.
- ras_n  output  1  SDRAM row strobe command bit.
- cas_n  output  1  SDRAM column strobe command bit.
- we_n  output  1  SDRAM write enable command bit.
- a10  output  1  precharge-all select bit.

Behaviour:
- All outputs registered. Async reset (reset=0) forces: FSM=IDLE, counters=0, ref_ack=0, ref_busy=0, cs_n=ras_n=cas_n=we_n=1, a10=0. Takes effect immediately, including mid-sequence; no partial command survives.
- Commands as {cs_n,ras_n,cas_n,we_n}, a10:
  - NOP = 0111, a10=0.
  - PALL = 0010, a10=1.
  - AREF = 0001, a10=0.
  - NOP is driven in every state except the single PALL and AREF cycles.
- States:
  - IDLE: ref_busy=0. If ref_req=1 and init_done=1 -> WAIT_IDLE. Otherwise stay.
  - WAIT_IDLE: ref_busy=1. If bank_busy=0 -> PRE. Otherwise stay; no timeout.
  - PRE: drive PALL for one cycle, load wait counter with T_RP-1, rep counter=0. If T_RP=1 -> AREF, else -> TRP.
  - TRP: NOP; decrement counter; at 0 -> AREF.
  - AREF: drive AREF for one cycle, rep counter +1, load counter T_RFC-1. If T_RFC=1 -> branch as at end of TRFC, else -> TRFC.
  - TRFC: NOP; decrement; at 0: if rep=REF_CNT -> ACK, else -> AREF.
  - ACK: ref_ack=1 for exactly one cycle, ref_busy=1 -> DONE.
  - DONE: ref_busy=0; ref_req ignored this cycle (timer clears it one clock after sampling ack) -> IDLE.
- Timing, with ref_req first sampled high at edge 0 and bank_busy=0:
  - ref_busy rises in cycle 1.
  - PALL in cycle 2.
  - AREF k (k=1..REF_CNT) in cycle 2+T_RP+(k-1)*T_RFC.
  - ref_ack in cycle 2+T_RP+REF_CNT*T_RFC.
  - ref_busy falls in the following cycle.
- ref_busy stays high from WAIT_IDLE through ACK inclusive.
- bank_busy is sampled only in WAIT_IDLE. Once PRE is entered, the sequence runs to completion regardless of bank_busy.
- ref_req dropping after WAIT_IDLE (timer reset) does not abort; the sequence completes and ref_ack still pulses.
- init_done dropping mid-sequence does not abort; it only gates the IDLE->WAIT_IDLE transition.
- Counters are 8-bit wait and 4-bit repeat; no wrap is possible within legal parameter ranges.

Test Plan:
- Defaults, init_done=1, bank_busy=0, ref_req rises before edge 0 -> ref_busy=1 in cycle 1, PALL (0010, a10=1) in cycle 2, AREF in cycles 5 and 12, ref_ack single pulse in cycle 19, ref_busy=0 in cycle 20, NOP in all other cycles.
- bank_busy=1 for cycles 0-9 -> FSM holds WAIT_IDLE with ref_busy=1 and NOP; PALL appears in cycle 11 (first cycle after bank_busy=0 is sampled), and all later events shift by 9.
- init_done=0 with ref_req=1 for 20 cycles -> no command, ref_busy=0. Raise init_done -> sequence starts per the default timing.
- ref_req held high one cycle past ref_ack (models the timer) -> no second sequence; FSM returns to IDLE; exactly one ref_ack. A new request 5 cycles later is serviced normally.
- reset pulled low in cycle 8 of a sequence -> outputs immediately at reset values (ref_busy=0, cmd=1111). After release with ref_req=1, a fresh sequence starts with PALL.
- Parameter set T_RP=1, T_RFC=1, REF_CNT=1 -> PALL in cycle 2, AREF in cycle 3, ref_ack in cycle 4.
